// File: rtl/io_clk_pkg.sv
// ---------------------------------------------------------------------------
// io_clk_pkg
// Shared definitions for the clock divider bank: the per-channel mode
// encoding carried in the top two bits of every configuration word, and a
// small helper used when deciding whether a channel produces strobes.
// ---------------------------------------------------------------------------
package io_clk_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF     = 2'b00,
        MODE_TOGGLE  = 2'b01,
        MODE_STROBE  = 2'b10,
        MODE_ONESHOT = 2'b11
    } divMode_e;

    // Both periodic and single-shot modes report an elapsed period on
    // div_strobe; only the toggle mode drives the level output.
    function automatic logic emitsStrobe(input divMode_e mode);
        return (mode == MODE_STROBE) || (mode == MODE_ONESHOT);
    endfunction

endpackage

// File: rtl/io_clk_divider_channel.sv
// ---------------------------------------------------------------------------
// io_clk_divider_channel
// One divider channel: a shadow configuration register written by the bank,
// the active configuration that drives the counter, and the registered
// div_clk / div_strobe / pending outputs.
//
// Ports
//   i_sysClk      system clock
//   i_syncRst     synchronous active-high reset (ignores i_clkEn)
//   i_clkEn       advance enable; all state holds while low
//   i_syncStart   phase-align request shared by every channel
//   i_write       write strobe for this channel's shadow register
//   i_writeData   {mode[1:0], divisor} to load into the shadow
//   o_active      active configuration (only with IO_CLK_DIV_READBACK_EN)
//   o_divClk      toggle-mode level output
//   o_divStrobe   one-cycle pulse after each elapsed period
//   o_pending     shadow holds a configuration not yet applied
// ---------------------------------------------------------------------------
module io_clk_divider_channel
    import io_clk_pkg::*;
#(
    parameter int DIV_WIDTH = 14
)
(
    input  logic                   i_sysClk,
    input  logic                   i_syncRst,
    input  logic                   i_clkEn,
    input  logic                   i_syncStart,
    input  logic                   i_write,
    input  logic [DIV_WIDTH+1:0]   i_writeData,
`ifdef IO_CLK_DIV_READBACK_EN
    output logic [DIV_WIDTH+1:0]   o_active,
`endif
    output logic                   o_divClk,
    output logic                   o_divStrobe,
    output logic                   o_pending
);

    logic [DIV_WIDTH+1:0] r_shadow;
    logic [DIV_WIDTH+1:0] r_active;
    logic [DIV_WIDTH-1:0] r_counter;
    logic                 r_divClk;
    logic                 r_divStrobe;
    logic                 r_pending;

    divMode_e             w_activeMode;
    divMode_e             w_shadowMode;
    logic [DIV_WIDTH-1:0] w_divisor;
    logic                 w_elapsed;
    logic                 w_apply;

    // Decode the active and shadow configurations and decide what happens
    // on this enabled cycle. sync_start suppresses the elapsed event so a
    // phase-align never also produces a strobe or a toggle. The shadow is
    // applied whenever the channel is idle, at a period boundary, or on a
    // phase-align, so a running output is never cut short mid-period.
    always_comb begin
        w_activeMode = divMode_e'(r_active[DIV_WIDTH +: MODE_W]);
        w_shadowMode = divMode_e'(r_shadow[DIV_WIDTH +: MODE_W]);
        w_divisor    = r_active[DIV_WIDTH-1:0];
        w_elapsed    = i_clkEn && !i_syncStart && (w_activeMode != MODE_OFF)
                       && (r_counter == w_divisor);
        w_apply      = i_clkEn && r_pending
                       && (i_syncStart || (w_activeMode == MODE_OFF) || w_elapsed);
    end

    // Channel state. A write landing in an apply cycle refills the shadow
    // (pending stays set) while the previous shadow becomes active. On
    // apply, div_clk keeps its phase only for a toggle-to-toggle change so
    // a mode switch can never leave a runt high phase behind.
    always_ff @(posedge i_sysClk) begin
        if (i_syncRst) begin
            r_shadow    <= '0;
            r_active    <= '0;
            r_counter   <= '0;
            r_divClk    <= 1'b0;
            r_divStrobe <= 1'b0;
            r_pending   <= 1'b0;
        end else if (i_clkEn) begin
            if (i_write) begin
                r_shadow  <= i_writeData;
                r_pending <= 1'b1;
            end else if (w_apply) begin
                r_pending <= 1'b0;
            end

            if (w_apply) begin
                r_active <= r_shadow;
            end else if (w_elapsed && (w_activeMode == MODE_ONESHOT)) begin
                r_active[DIV_WIDTH +: MODE_W] <= MODE_OFF;
            end

            if (i_syncStart || w_apply || w_elapsed || (w_activeMode == MODE_OFF)) begin
                r_counter <= '0;
            end else begin
                r_counter <= r_counter + 1'b1;
            end

            if (i_syncStart) begin
                r_divClk <= 1'b0;
            end else if (w_apply) begin
                r_divClk <= ((w_activeMode == MODE_TOGGLE) && (w_shadowMode == MODE_TOGGLE))
                            ? ~r_divClk : 1'b0;
            end else if (w_activeMode == MODE_TOGGLE) begin
                r_divClk <= r_divClk ^ w_elapsed;
            end else begin
                r_divClk <= 1'b0;
            end

            r_divStrobe <= w_elapsed && emitsStrobe(w_activeMode);
        end
    end

`ifdef IO_CLK_DIV_READBACK_EN
    assign o_active    = r_active;
`endif
    assign o_divClk    = r_divClk;
    assign o_divStrobe = r_divStrobe;
    assign o_pending   = r_pending;

endmodule

// File: rtl/io_clk_divider_bank.sv
// ---------------------------------------------------------------------------
// io_clk_divider_bank
// A bank of CHANNELS independent programmable dividers sharing one clock.
// This level decodes configuration writes to a channel, fans sync_start
// out to every channel and, when IO_CLK_DIV_READBACK_EN is defined, muxes
// the selected channel's active configuration onto cfg_read_data (tied to
// zero otherwise).
//
// Ports
//   sys_clk          the only clock
//   sync_rst         synchronous active-high reset
//   clk_en           global advance / write-accept enable
//   cfg_write_en     write cfg_data into the selected channel's shadow
//   cfg_channel_sel  channel select for writes and readback
//   cfg_data         {mode[1:0], divisor}
//   sync_start       phase-align all channels
//   cfg_read_data    active configuration of the selected channel
//   div_clk          per-channel toggle outputs
//   div_strobe       per-channel one-cycle pulses
//   cfg_pending      per-channel shadow-not-yet-applied flags
// ---------------------------------------------------------------------------
module io_clk_divider_bank
    import io_clk_pkg::*;
#(
    parameter  int CHANNELS  = 4,
    parameter  int DIV_WIDTH = 14,
    localparam int SEL_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int CFG_W     = DIV_WIDTH + MODE_W
)
(
    input  logic                sys_clk,
    input  logic                sync_rst,
    input  logic                clk_en,
    input  logic                cfg_write_en,
    input  logic [SEL_W-1:0]    cfg_channel_sel,
    input  logic [CFG_W-1:0]    cfg_data,
    input  logic                sync_start,
    output logic [CFG_W-1:0]    cfg_read_data,
    output logic [CHANNELS-1:0] div_clk,
    output logic [CHANNELS-1:0] div_strobe,
    output logic [CHANNELS-1:0] cfg_pending
);

    logic [CHANNELS-1:0] w_chanWrite;
`ifdef IO_CLK_DIV_READBACK_EN
    logic [CFG_W-1:0]    w_active [CHANNELS];
`endif

    // One channel per generate iteration; a select value beyond the last
    // channel matches no iteration, so such writes are simply dropped.
    for (genvar g = 0; g < CHANNELS; g++) begin : gen_chan
        assign w_chanWrite[g] = cfg_write_en && (cfg_channel_sel == SEL_W'(g));

        io_clk_divider_channel #(
            .DIV_WIDTH (DIV_WIDTH)
        ) u_chan (
            .i_sysClk    (sys_clk),
            .i_syncRst   (sync_rst),
            .i_clkEn     (clk_en),
            .i_syncStart (sync_start),
            .i_write     (w_chanWrite[g]),
            .i_writeData (cfg_data),
`ifdef IO_CLK_DIV_READBACK_EN
            .o_active    (w_active[g]),
`endif
            .o_divClk    (div_clk[g]),
            .o_divStrobe (div_strobe[g]),
            .o_pending   (cfg_pending[g])
        );
    end

`ifdef IO_CLK_DIV_READBACK_EN
    // Combinational readback of the active configuration; an out-of-range
    // select finds no matching channel and reads as zero.
    always_comb begin
        cfg_read_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_channel_sel == SEL_W'(i)) begin
                cfg_read_data = w_active[i];
            end
        end
    end
`else
    assign cfg_read_data = '0;
`endif

endmodule

// File: tb/tb_io_clk_divider_bank.sv
// ---------------------------------------------------------------------------
// tb_io_clk_divider_bank
// Directed scenarios for the divider bank. Each step drives inputs, pushes
// the outputs expected after the next clock edge onto a scoreboard queue,
// and the queue is drained and compared one time unit after that edge.
// ---------------------------------------------------------------------------
module tb_io_clk_divider_bank;

    localparam int CHANNELS  = 4;
    localparam int DIV_WIDTH = 14;
    localparam int CFG_W     = DIV_WIDTH + 2;

    logic                sys_clk = 1'b0;
    logic                sync_rst;
    logic                clk_en;
    logic                cfg_write_en;
    logic [1:0]          cfg_channel_sel;
    logic [CFG_W-1:0]    cfg_data;
    logic                sync_start;
    logic [CFG_W-1:0]    cfg_read_data;
    logic [CHANNELS-1:0] div_clk;
    logic [CHANNELS-1:0] div_strobe;
    logic [CHANNELS-1:0] cfg_pending;

    typedef enum int {SIG_CLK, SIG_STROBE, SIG_PENDING, SIG_READ} sigKind_e;

    typedef struct {
        string       tag;
        sigKind_e    kind;
        logic [31:0] expected;
    } expItem_t;

    expItem_t scoreboard[$];
    int       errorCount = 0;
    int       checkCount = 0;

    io_clk_divider_bank #(
        .CHANNELS  (CHANNELS),
        .DIV_WIDTH (DIV_WIDTH)
    ) dut (
        .sys_clk         (sys_clk),
        .sync_rst        (sync_rst),
        .clk_en          (clk_en),
        .cfg_write_en    (cfg_write_en),
        .cfg_channel_sel (cfg_channel_sel),
        .cfg_data        (cfg_data),
        .sync_start      (sync_start),
        .cfg_read_data   (cfg_read_data),
        .div_clk         (div_clk),
        .div_strobe      (div_strobe),
        .cfg_pending     (cfg_pending)
    );

    // Free-running 10-unit clock.
    initial forever #5 sys_clk = ~sys_clk;

    function automatic logic [CFG_W-1:0] cfgWord(input logic [1:0] mode, input int divisor);
        return {mode, DIV_WIDTH'(divisor)};
    endfunction

    // Readback is only built when the macro is defined; otherwise it reads 0.
    function automatic logic [31:0] readExp(input logic [CFG_W-1:0] value);
`ifdef IO_CLK_DIV_READBACK_EN
        return 32'(value);
`else
        return (value == value) ? 32'd0 : 32'd0;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic expectOut(input string tag, input sigKind_e kind, input logic [31:0] value);
        expItem_t item;
        item.tag      = tag;
        item.kind     = kind;
        item.expected = value;
        scoreboard.push_back(item);
    endtask

    task automatic applyStimulus(input logic en, input logic wr, input int sel,
                                 input logic [CFG_W-1:0] data, input logic sync);
        clk_en          = en;
        cfg_write_en    = wr;
        cfg_channel_sel = 2'(sel);
        cfg_data        = data;
        sync_start      = sync;
    endtask

    // Advance one edge, then compare everything queued for it.
    task automatic tick();
        expItem_t    item;
        logic [31:0] actual;
        @(posedge sys_clk);
        #1;
        while (scoreboard.size() > 0) begin
            item = scoreboard.pop_front();
            case (item.kind)
                SIG_CLK:     actual = 32'(div_clk);
                SIG_STROBE:  actual = 32'(div_strobe);
                SIG_PENDING: actual = 32'(cfg_pending);
                default:     actual = 32'(cfg_read_data);
            endcase
            checkOutput(item.tag, actual, item.expected);
        end
    endtask

    task automatic expectQuiet(input string tag);
        expectOut({tag, "_clk"},  SIG_CLK,     32'd0);
        expectOut({tag, "_stb"},  SIG_STROBE,  32'd0);
        expectOut({tag, "_pend"}, SIG_PENDING, 32'd0);
    endtask

    // Reset with clk_en low to show reset does not depend on the enable.
    task automatic applyReset();
        applyStimulus(1'b0, 1'b0, 0, '0, 1'b0);
        sync_rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            expectQuiet($sformatf("rst%0d", i));
            tick();
        end
        sync_rst = 1'b0;
    endtask

    initial begin
        int e;
        sync_rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 0, '0, 1'b0);

        // Toggle channel 0, divisor 3: pending for one cycle, period 8.
        applyReset();
        applyStimulus(1'b1, 1'b1, 0, cfgWord(2'b01, 3), 1'b0);
        expectOut("A_pendSet", SIG_PENDING, 32'h1);
        expectOut("A_clkW", SIG_CLK, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 0, '0, 1'b0);
        expectOut("A_pendClr", SIG_PENDING, 32'h0);
        expectOut("A_clkApply", SIG_CLK, 32'h0);
        expectOut("A_read", SIG_READ, readExp(cfgWord(2'b01, 3)));
        tick();
        for (int k = 1; k <= 16; k++) begin
            expectOut($sformatf("A_clk_k%0d", k), SIG_CLK, 32'((k / 4) % 2));
            expectOut($sformatf("A_stb_k%0d", k), SIG_STROBE, 32'h0);
            tick();
        end

        // Channel 1 strobe divisor 0, then divisor 2 written while running.
        applyReset();
        applyStimulus(1'b1, 1'b1, 1, cfgWord(2'b10, 0), 1'b0);
        expectOut("B_pendSet", SIG_PENDING, 32'h2);
        expectOut("B_stbW", SIG_STROBE, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 1, '0, 1'b0);
        expectOut("B_pendClr", SIG_PENDING, 32'h0);
        expectOut("B_stbApply", SIG_STROBE, 32'h0);
        tick();
        for (int j = 1; j <= 5; j++) begin
            expectOut($sformatf("B_stbCont_%0d", j), SIG_STROBE, 32'h2);
            tick();
        end
        applyStimulus(1'b1, 1'b1, 1, cfgWord(2'b10, 2), 1'b0);
        expectOut("B_stbW2", SIG_STROBE, 32'h2);
        expectOut("B_pendW2", SIG_PENDING, 32'h2);
        tick();
        applyStimulus(1'b1, 1'b0, 1, '0, 1'b0);
        expectOut("B_stbApply2", SIG_STROBE, 32'h2);
        expectOut("B_pendApply2", SIG_PENDING, 32'h0);
        tick();
        for (int j = 1; j <= 9; j++) begin
            expectOut($sformatf("B_stbDiv2_%0d", j), SIG_STROBE, (j % 3 == 0) ? 32'h2 : 32'h0);
            expectOut($sformatf("B_clk_%0d", j), SIG_CLK, 32'h0);
            tick();
        end

        // Channel 2 one-shot divisor 5: a single pulse, then mode reads OFF.
        applyReset();
        applyStimulus(1'b1, 1'b1, 2, cfgWord(2'b11, 5), 1'b0);
        expectOut("C_pendSet", SIG_PENDING, 32'h4);
        tick();
        applyStimulus(1'b1, 1'b0, 2, '0, 1'b0);
        expectOut("C_pendClr", SIG_PENDING, 32'h0);
        expectOut("C_readArmed", SIG_READ, readExp(cfgWord(2'b11, 5)));
        tick();
        for (int k = 1; k <= 14; k++) begin
            expectOut($sformatf("C_stb_k%0d", k), SIG_STROBE, (k == 6) ? 32'h4 : 32'h0);
            tick();
        end
        expectOut("C_readOff", SIG_READ, readExp(cfgWord(2'b00, 5)));
        expectOut("C_pendEnd", SIG_PENDING, 32'h0);
        tick();

        // Channel 0 toggle divisor 1 with clk_en alternating; writes while
        // disabled must be dropped.
        applyReset();
        applyStimulus(1'b1, 1'b1, 0, cfgWord(2'b01, 1), 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 0, '0, 1'b0);
        expectOut("D_clkApply", SIG_CLK, 32'h0);
        tick();
        e = 0;
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) begin
                applyStimulus(1'b1, 1'b0, 0, '0, 1'b0);
                e++;
            end else begin
                applyStimulus(1'b0, 1'b1, 0, cfgWord(2'b10, 0), 1'b0);
            end
            expectOut($sformatf("D_clk_%0d", i), SIG_CLK, 32'((e / 2) % 2));
            expectOut($sformatf("D_pend_%0d", i), SIG_PENDING, 32'h0);
            expectOut($sformatf("D_stb_%0d", i), SIG_STROBE, 32'h0);
            tick();
        end

        // Four toggle channels, divisors 1..4, phase-aligned by sync_start.
        applyReset();
        for (int ch = 0; ch < 4; ch++) begin
            applyStimulus(1'b1, 1'b1, ch, cfgWord(2'b01, ch + 1), 1'b0);
            tick();
        end
        applyStimulus(1'b1, 1'b0, 0, '0, 1'b0);
        for (int i = 0; i < 7; i++) tick();
        applyStimulus(1'b1, 1'b1, 3, cfgWord(2'b01, 4), 1'b0);
        expectOut("E_pendPreSync", SIG_PENDING, 32'h8);
        tick();
        applyStimulus(1'b1, 1'b0, 0, '0, 1'b1);
        expectOut("E_clkSync", SIG_CLK, 32'h0);
        expectOut("E_pendSync", SIG_PENDING, 32'h0);
        expectOut("E_stbSync", SIG_STROBE, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 0, '0, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            logic [31:0] vec;
            vec = '0;
            for (int ch = 0; ch < 4; ch++) begin
                vec[ch] = ((k / (ch + 2)) % 2) == 1;
            end
            expectOut($sformatf("E_clk_k%0d", k), SIG_CLK, vec);
            tick();
        end

        // Reset in mid-period with a write pending: everything stops.
        applyReset();
        applyStimulus(1'b1, 1'b1, 0, cfgWord(2'b01, 3), 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 0, '0, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        applyStimulus(1'b1, 1'b1, 1, cfgWord(2'b10, 1), 1'b0);
        expectOut("F_clkHigh", SIG_CLK, 32'h1);
        expectOut("F_pendSet", SIG_PENDING, 32'h2);
        tick();
        applyStimulus(1'b1, 1'b0, 0, '0, 1'b0);
        sync_rst = 1'b1;
        expectQuiet("F_rst");
        tick();
        sync_rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            expectQuiet($sformatf("F_idle%0d", i));
            tick();
        end
        expectOut("F_read", SIG_READ, 32'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/io_clk_divider_bank.md
IO_CLK_DIVIDER_BANK -- requirements
Module: io_clk_divider_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent divider channels, 1..16.
REQ-002 SHALL have parameter DIV_WIDTH, default 14: divisor and counter width, 2..16.
REQ-003 SHALL have ports: sys_clk in 1, the only clock. sync_rst in 1, synchronous active-high reset. clk_en in 1, global advance/accept enable.
REQ-004 SHALL have ports: cfg_write_en in 1, cfg_channel_sel in clog2(CHANNELS) (min 1), cfg_data in DIV_WIDTH+2 as {mode[1:0], divisor}.
REQ-005 SHALL have ports: sync_start in 1 (phase-align all channels) and cfg_read_data out DIV_WIDTH+2 (active config of cfg_channel_sel).
REQ-006 SHALL have ports: div_clk out CHANNELS (level outputs), div_strobe out CHANNELS (1-cycle pulses), cfg_pending out CHANNELS.

Function
REQ-007 SHALL decode mode as 00 OFF, 01 TOGGLE (div_clk), 10 STROBE (periodic div_strobe), 11 ONESHOT (single div_strobe).
REQ-008 SHALL advance all channel state only on cycles with clk_en=1; with clk_en=0 all state, including shadows, holds.
REQ-009 SHALL count 0..divisor per channel; elapsed = (counter == divisor) && clk_en; on elapsed counter returns to 0, else increments.
REQ-010 SHALL in TOGGLE invert div_clk on each elapsed: period 2*(divisor+1) enabled cycles, 50% duty.
REQ-011 SHALL in STROBE register div_strobe high for exactly the cycle after each elapsed; divisor=0 gives div_strobe continuously high.
REQ-012 SHALL in ONESHOT emit one div_strobe after divisor+1 enabled cycles, then set the active mode to OFF.
REQ-013 SHALL in OFF hold counter at 0, div_clk at 0, div_strobe at 0.
REQ-014 SHALL on cfg_write_en && clk_en load cfg_data into the selected channel's shadow register and set cfg_pending; a cfg_channel_sel >= CHANNELS is ignored.
REQ-015 SHALL apply shadow to active config when pending and (active mode OFF, or elapsed); apply clears pending and zeroes counter.
REQ-016 SHALL on apply set div_clk to ~div_clk if old and new modes are both TOGGLE, else 0: no runt high phase.
REQ-017 SHALL let a write while pending overwrite the shadow, pending staying 1; a write in an apply cycle goes to the shadow, applied value is the previous shadow.
REQ-018 SHALL on sync_start && clk_en zero all counters and div_clk, clear div_strobe, and apply every pending shadow in the same cycle; sync_start has priority over elapsed.
REQ-019 SHALL drive cfg_read_data combinationally from the active (not shadow) config; 0 for out-of-range select.
REQ-020 SHALL drive div_clk, div_strobe and cfg_pending from flops only.

Reset
REQ-021 SHALL on sync_rst, regardless of clk_en, clear active and shadow to 0 (OFF, divisor 0), counters 0, div_clk 0, div_strobe 0, cfg_pending 0.
REQ-022 SHALL abort in-flight periods and pending writes on reset mid-operation; first output activity after reset needs a new write.

Configuration
REQ-023 SHALL support macro IO_CLK_DIV_READBACK_EN: defined -> cfg_read_data per REQ-019; undefined -> cfg_read_data tied 0 and readback mux not built.

Structure
REQ-024 SHALL place mode enum (OFF/TOGGLE/STROBE/ONESHOT) and mode width constant in shared package io_clk_pkg.
REQ-025 SHALL instantiate sub-module io_clk_divider_channel per channel (shadow, active, counter, outputs); top holds write decode, sync_start fan-out, readback mux.

Verification
REQ-026 SHALL cover reset then write ch0 {01, 3}, clk_en=1 -> cfg_pending[0] 1 cycle, div_clk[0] toggles every 4 cycles, period 8.
REQ-027 SHALL cover ch1 {10, 0} then {10, 2} while running -> strobe every cycle, then every 3rd cycle starting right after the current period ends.
REQ-028 SHALL cover ch2 {11, 5} -> exactly one div_strobe[2], 6 cycles after apply, then cfg_read_data mode 00 with sel=2.
REQ-029 SHALL cover clk_en toggled 1/0 with ch0 TOGGLE divisor 1 -> period doubles to 8 sys_clk; write during clk_en=0 ignored.
REQ-030 SHALL cover channels 0..3 TOGGLE with divisors 1,2,3,4 then sync_start -> all div_clk 0 and counters 0 same cycle, rising edges thereafter at 2,3,4,5 cycles.
REQ-031 SHALL cover sync_rst mid-period with pending write -> all outputs 0, cfg_pending 0, no further activity.
